// File: rtl/ppc_types.sv
// Shared types for the divide reservation station: decode bundle, entry state and entry record.
package ppc_types;

  // Stored tags are held at this fixed width so the entry record can live in a package.
  localparam int RS_TAG_MAX_W = 8;

  typedef enum logic [1:0] {
    DIV_OP_DIV,
    DIV_OP_DIVU,
    DIV_OP_REM,
    DIV_OP_REMU
  } div_op_t;

  typedef struct packed {
    div_op_t op;
    logic    set_ov;
    logic    set_cr0;
  } div_decode_t;

  // FREE must encode as zero so a cleared entry record is a free entry.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    READY  = 2'd2,
    ISSUED = 2'd3
  } rs_entry_state_t;

  typedef struct packed {
    rs_entry_state_t         state;
    logic [31:0]             op1;
    logic [31:0]             op2;
    logic                    op1_valid;
    logic                    op2_valid;
    logic [RS_TAG_MAX_W-1:0] op1_tag;
    logic [RS_TAG_MAX_W-1:0] op2_tag;
    logic [4:0]              reg_addr;
    div_decode_t             control;
  } rs_entry_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder: reports whether any request bit is set and the index of the lowest one.
module rs_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/div_rs.sv
// Divide reservation station: holds dispatched divides until both operands arrive, then issues in index order.
// Optional macro DIV_RS_BYPASS_EN lets a ready dispatch load the issue register directly into an idle station.
module div_rs
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_ENTRIES  = 4,
  parameter int RS_ID_BASE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic                   op1_valid_in,
  input  logic [31:0]            op1_in,
  input  logic [RS_ID_WIDTH-1:0] op1_tag_in,
  input  logic                   op2_valid_in,
  input  logic [31:0]            op2_in,
  input  logic [RS_ID_WIDTH-1:0] op2_tag_in,
  input  logic [4:0]             result_reg_addr_in,
  input  div_decode_t            control_in,
  output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_result_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output div_decode_t            issue_control
);

  // Both handshakes transfer on a rising edge where valid and ready are high together; the
  // issue side holds every issue_* output stable while valid is high and ready is low.

  localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;
  localparam logic [RS_ID_WIDTH-1:0] ID_BASE = RS_ID_WIDTH'(RS_ID_BASE);

  function automatic logic [RS_ID_WIDTH-1:0] tag_of(input int k);
    return ID_BASE + RS_ID_WIDTH'(k);
  endfunction

  rs_entry_t ents [RS_ENTRIES];

  logic [RS_ENTRIES-1:0] free_vec;
  logic [RS_ENTRIES-1:0] ready_vec;
  logic [RS_ENTRIES-1:0] cap1;
  logic [RS_ENTRIES-1:0] cap2;
  logic [RS_ENTRIES-1:0] done;

  logic                    alloc_found;
  logic [IDX_W-1:0]        alloc_idx;
  logic                    sel_found;
  logic [IDX_W-1:0]        sel_idx;
  logic [RS_TAG_MAX_W-1:0] cdb_tag;

  logic        dispatch_fire;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic        d_op1_valid;
  logic        d_op2_valid;
  logic [31:0] d_op1;
  logic [31:0] d_op2;
  logic        d_ready;
  logic        issue_load;
  logic        bypass;

  assign cdb_tag = RS_TAG_MAX_W'(cdb_rs_id);

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    cap1      = '0;
    cap2      = '0;
    done      = '0;
    for (int k = 0; k < RS_ENTRIES; k++) begin
      free_vec[k]  = (ents[k].state == FREE);
      ready_vec[k] = (ents[k].state == READY);
      cap1[k]      = (ents[k].state == WAIT) && !ents[k].op1_valid && cdb_valid &&
                     (ents[k].op1_tag == cdb_tag);
      cap2[k]      = (ents[k].state == WAIT) && !ents[k].op2_valid && cdb_valid &&
                     (ents[k].op2_tag == cdb_tag);
      done[k]      = (ents[k].state == ISSUED) && cdb_valid && (cdb_rs_id == tag_of(k));
    end
  end

  rs_prio_enc #(
    .N     (RS_ENTRIES),
    .IDX_W (IDX_W)
  ) u_alloc_enc (
    .req   (free_vec),
    .found (alloc_found),
    .idx   (alloc_idx)
  );

  rs_prio_enc #(
    .N     (RS_ENTRIES),
    .IDX_W (IDX_W)
  ) u_issue_enc (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Readiness comes from registered state only, so an entry freed this cycle is not offered yet.
  assign dispatch_ready = alloc_found;
  assign dispatch_rs_id = ID_BASE + RS_ID_WIDTH'(alloc_idx);
  assign dispatch_fire  = dispatch_valid && alloc_found;

  assign fwd1_hit    = !op1_valid_in && cdb_valid && (cdb_rs_id == op1_tag_in);
  assign fwd2_hit    = !op2_valid_in && cdb_valid && (cdb_rs_id == op2_tag_in);
  assign d_op1_valid = op1_valid_in || fwd1_hit;
  assign d_op2_valid = op2_valid_in || fwd2_hit;
  assign d_op1       = fwd1_hit ? cdb_result : op1_in;
  assign d_op2       = fwd2_hit ? cdb_result : op2_in;
  assign d_ready     = d_op1_valid && d_op2_valid;

  assign issue_load = !issue_valid || issue_ready;

`ifdef DIV_RS_BYPASS_EN
  // Only when nothing older is READY, so bypassing never overtakes a waiting entry.
  assign bypass = dispatch_fire && d_ready && issue_load && !sel_found;
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RS_ENTRIES; k++) begin
        ents[k] <= '0;
      end
    end else begin
      for (int k = 0; k < RS_ENTRIES; k++) begin
        case (ents[k].state)
          WAIT: begin
            if (cap1[k]) begin
              ents[k].op1       <= cdb_result;
              ents[k].op1_valid <= 1'b1;
            end
            if (cap2[k]) begin
              ents[k].op2       <= cdb_result;
              ents[k].op2_valid <= 1'b1;
            end
            if ((ents[k].op1_valid || cap1[k]) && (ents[k].op2_valid || cap2[k])) begin
              ents[k].state <= READY;
            end
          end
          ISSUED: begin
            if (done[k]) begin
              ents[k].state <= FREE;
            end
          end
          default: ;
        endcase
      end

      if (issue_load && sel_found) begin
        ents[sel_idx].state <= ISSUED;
      end

      if (dispatch_fire) begin
        ents[alloc_idx] <= '{
          state:     bypass ? ISSUED : (d_ready ? READY : WAIT),
          op1:       d_op1,
          op2:       d_op2,
          op1_valid: d_op1_valid,
          op2_valid: d_op2_valid,
          op1_tag:   RS_TAG_MAX_W'(op1_tag_in),
          op2_tag:   RS_TAG_MAX_W'(op2_tag_in),
          reg_addr:  result_reg_addr_in,
          control:   control_in
        };
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid           <= 1'b0;
      issue_rs_id           <= '0;
      issue_result_reg_addr <= '0;
      issue_op1             <= '0;
      issue_op2             <= '0;
      issue_control         <= '0;
    end else if (bypass) begin
      issue_valid           <= 1'b1;
      issue_rs_id           <= dispatch_rs_id;
      issue_result_reg_addr <= result_reg_addr_in;
      issue_op1             <= d_op1;
      issue_op2             <= d_op2;
      issue_control         <= control_in;
    end else if (issue_load) begin
      issue_valid <= sel_found;
      if (sel_found) begin
        issue_rs_id           <= ID_BASE + RS_ID_WIDTH'(sel_idx);
        issue_result_reg_addr <= ents[sel_idx].reg_addr;
        issue_op1             <= ents[sel_idx].op1;
        issue_op2             <= ents[sel_idx].op2;
        issue_control         <= ents[sel_idx].control;
      end
    end
  end

endmodule

// File: tb/tb_div_rs.sv
// Directed bench for div_rs: a monitor pops expected issue records as the divider side accepts them.
module tb_div_rs;
  import ppc_types::*;

  localparam int IDW   = 5;
  localparam int NE    = 4;
  localparam int REC_W = IDW + 5 + 32 + 32 + $bits(div_decode_t);

  localparam div_decode_t CTRL_A = '{op: DIV_OP_DIVU, set_ov: 1'b1, set_cr0: 1'b0};
  localparam div_decode_t CTRL_B = '{op: DIV_OP_REM,  set_ov: 1'b0, set_cr0: 1'b1};
  localparam div_decode_t CTRL_C = '{op: DIV_OP_REMU, set_ov: 1'b1, set_cr0: 1'b1};

  logic             clk;
  logic             rst;
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic             op1_valid_in;
  logic [31:0]      op1_in;
  logic [IDW-1:0]   op1_tag_in;
  logic             op2_valid_in;
  logic [31:0]      op2_in;
  logic [IDW-1:0]   op2_tag_in;
  logic [4:0]       result_reg_addr_in;
  div_decode_t      control_in;
  logic [IDW-1:0]   dispatch_rs_id;
  logic             cdb_valid;
  logic [IDW-1:0]   cdb_rs_id;
  logic [31:0]      cdb_result;
  logic             issue_valid;
  logic             issue_ready;
  logic [IDW-1:0]   issue_rs_id;
  logic [4:0]       issue_result_reg_addr;
  logic [31:0]      issue_op1;
  logic [31:0]      issue_op2;
  div_decode_t      issue_control;

  int n_tests = 0;
  int n_fail  = 0;
  logic [REC_W-1:0] exp_q[$];

  div_rs #(
    .RS_ID_WIDTH (IDW),
    .RS_ENTRIES  (NE),
    .RS_ID_BASE  (0)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .dispatch_valid        (dispatch_valid),
    .dispatch_ready        (dispatch_ready),
    .op1_valid_in          (op1_valid_in),
    .op1_in                (op1_in),
    .op1_tag_in            (op1_tag_in),
    .op2_valid_in          (op2_valid_in),
    .op2_in                (op2_in),
    .op2_tag_in            (op2_tag_in),
    .result_reg_addr_in    (result_reg_addr_in),
    .control_in            (control_in),
    .dispatch_rs_id        (dispatch_rs_id),
    .cdb_valid             (cdb_valid),
    .cdb_rs_id             (cdb_rs_id),
    .cdb_result            (cdb_result),
    .issue_valid           (issue_valid),
    .issue_ready           (issue_ready),
    .issue_rs_id           (issue_rs_id),
    .issue_result_reg_addr (issue_result_reg_addr),
    .issue_op1             (issue_op1),
    .issue_op2             (issue_op2),
    .issue_control         (issue_control)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    dispatch_valid     = 1'b0;
    op1_valid_in       = 1'b0;
    op1_in             = '0;
    op1_tag_in         = '0;
    op2_valid_in       = 1'b0;
    op2_in             = '0;
    op2_tag_in         = '0;
    result_reg_addr_in = '0;
    control_in         = '0;
    cdb_valid          = 1'b0;
    cdb_rs_id          = '0;
    cdb_result         = '0;
  endtask

  task automatic cycle_begin();
    step();
    clear_inputs();
  endtask

  task automatic drive_dispatch(input logic v1, input logic [31:0] o1, input logic [IDW-1:0] t1,
                                input logic v2, input logic [31:0] o2, input logic [IDW-1:0] t2,
                                input logic [4:0] addr, input div_decode_t ctrl);
    dispatch_valid     = 1'b1;
    op1_valid_in       = v1;
    op1_in             = o1;
    op1_tag_in         = t1;
    op2_valid_in       = v2;
    op2_in             = o2;
    op2_tag_in         = t2;
    result_reg_addr_in = addr;
    control_in         = ctrl;
  endtask

  task automatic drive_cdb(input logic [IDW-1:0] tag, input logic [31:0] val);
    cdb_valid  = 1'b1;
    cdb_rs_id  = tag;
    cdb_result = val;
  endtask

  task automatic free_tag(input logic [IDW-1:0] tag);
    cycle_begin();
    drive_cdb(tag, 32'hdead_beef);
    mid();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted issue must match the oldest expected record
  always @(negedge clk) begin
    logic [REC_W-1:0] act;
    logic [REC_W-1:0] exp;
    if (!rst && issue_valid && issue_ready) begin
      act = {issue_rs_id, issue_result_reg_addr, issue_op1, issue_op2, issue_control};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue: got %h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL issue_data: got %h expected %h", act, exp);
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    issue_ready = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mid();
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_rs_id", 32'(issue_rs_id), 32'd0);
    check("rst_issue_addr", 32'(issue_result_reg_addr), 32'd0);
    check("rst_issue_op1", issue_op1, 32'd0);
    check("rst_issue_op2", issue_op2, 32'd0);
    check("rst_issue_control", 32'(issue_control), 32'd0);
    check("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);

    // Both operands ready: issue two cycles later
    cycle_begin();
    issue_ready = 1'b1;
    drive_dispatch(1'b1, 32'd100, '0, 1'b1, 32'd7, '0, 5'd3, CTRL_A);
    exp_q.push_back({5'd0, 5'd3, 32'd100, 32'd7, CTRL_A});
    mid();
    check("a_dispatch_ready", 32'(dispatch_ready), 32'd1);
    check("a_dispatch_rs_id", 32'(dispatch_rs_id), 32'd0);
    cycle_begin();
    mid();
`ifdef DIV_RS_BYPASS_EN
    check("a_valid_n1", 32'(issue_valid), 32'd1);
`else
    check("a_valid_n1", 32'(issue_valid), 32'd0);
`endif
    cycle_begin();
    mid();
`ifdef DIV_RS_BYPASS_EN
    check("a_valid_n2", 32'(issue_valid), 32'd0);
`else
    check("a_valid_n2", 32'(issue_valid), 32'd1);
`endif
    free_tag(5'd0);

    // op2 waits on tag 3; an unrelated broadcast must be ignored
    cycle_begin();
    drive_dispatch(1'b1, 32'd40, '0, 1'b0, 32'd0, 5'd3, 5'd4, CTRL_B);
    exp_q.push_back({5'd0, 5'd4, 32'd40, 32'd5, CTRL_B});
    mid();
    check("b_dispatch_rs_id", 32'(dispatch_rs_id), 32'd0);
    cycle_begin();
    drive_cdb(5'd7, 32'd99);
    mid();
    cycle_begin();
    mid();
    check("b_ignore_tag7", 32'(issue_valid), 32'd0);
    cycle_begin();
    drive_cdb(5'd3, 32'd5);
    mid();
    check("b_cdb_cycle", 32'(issue_valid), 32'd0);
    cycle_begin();
    mid();
    check("b_ready_cycle", 32'(issue_valid), 32'd0);
    cycle_begin();
    mid();
    check("b_issue_after_ready", 32'(issue_valid), 32'd1);
    free_tag(5'd0);

    // Broadcast in the same cycle as the dispatch that needs it
    cycle_begin();
    drive_dispatch(1'b1, 32'd9, '0, 1'b0, 32'd0, 5'd3, 5'd5, CTRL_C);
    drive_cdb(5'd3, 32'd5);
    exp_q.push_back({5'd0, 5'd5, 32'd9, 32'd5, CTRL_C});
    mid();
    cycle_begin();
    mid();
`ifdef DIV_RS_BYPASS_EN
    check("c_valid_n1", 32'(issue_valid), 32'd1);
`else
    check("c_valid_n1", 32'(issue_valid), 32'd0);
`endif
    cycle_begin();
    mid();
`ifdef DIV_RS_BYPASS_EN
    check("c_valid_n2", 32'(issue_valid), 32'd0);
`else
    check("c_valid_n2", 32'(issue_valid), 32'd1);
`endif
    free_tag(5'd0);

    // Fill the station while the divider stalls
    for (int k = 0; k < NE; k++) begin
      cycle_begin();
      issue_ready = 1'b0;
      drive_dispatch(1'b1, 32'(1000 + k), '0, 1'b1, 32'(k + 1), '0, 5'(10 + k), CTRL_A);
      exp_q.push_back({5'(k), 5'(10 + k), 32'(1000 + k), 32'(k + 1), CTRL_A});
      mid();
      check("d_dispatch_rs_id", 32'(dispatch_rs_id), 32'(k));
    end
    cycle_begin();
    mid();
    check("d_full", 32'(dispatch_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("d_hold_valid", 32'(issue_valid), 32'd1);
      check("d_hold_op1", issue_op1, 32'd1000);
      check("d_hold_rs_id", 32'(issue_rs_id), 32'd0);
      cycle_begin();
      mid();
    end
    cycle_begin();
    issue_ready = 1'b1;
    mid();
    for (int c = 0; c < 4; c++) begin
      cycle_begin();
      mid();
    end
    check("d_drained_valid", 32'(issue_valid), 32'd0);
    check("d_drained_queue", 32'(exp_q.size()), 32'd0);
    check("d_all_issued", 32'(dispatch_ready), 32'd0);
    cycle_begin();
    drive_cdb(5'd2, 32'd0);
    mid();
    check("d_freed_same_cycle", 32'(dispatch_ready), 32'd0);
    cycle_begin();
    mid();
    check("d_freed_next_cycle", 32'(dispatch_ready), 32'd1);
    check("d_freed_rs_id", 32'(dispatch_rs_id), 32'd2);
    free_tag(5'd0);
    free_tag(5'd1);
    free_tag(5'd3);

    // Reset with three occupied entries discards everything
    for (int k = 0; k < 3; k++) begin
      cycle_begin();
      issue_ready = 1'b0;
      drive_dispatch(1'b1, 32'(500 + k), '0, 1'b1, 32'd3, '0, 5'd20, CTRL_B);
      mid();
    end
    cycle_begin();
    rst = 1'b1;
    mid();
    cycle_begin();
    rst = 1'b0;
    mid();
    check("e_issue_valid", 32'(issue_valid), 32'd0);
    check("e_dispatch_ready", 32'(dispatch_ready), 32'd1);
    check("e_dispatch_rs_id", 32'(dispatch_rs_id), 32'd0);
    cycle_begin();
    issue_ready = 1'b1;
    mid();
    for (int c = 0; c < 4; c++) begin
      check("e_no_stale", 32'(issue_valid), 32'd0);
      cycle_begin();
      mid();
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
